// File: rtl/sram_like_arbiter_if.sv
// Core-side instruction/data SRAM-like ports plus the shared downstream master port.
// "master" is the arbiter's view; "slave" is the surrounding core + memory view.
interface sram_like_arbiter_if;
  logic        i_req;
  logic        i_wr;
  logic [1:0]  i_size;
  logic [3:0]  i_wstrb;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic        i_addr_ok;
  logic        i_data_ok;
  logic [31:0] i_rdata;

  logic        d_req;
  logic        d_wr;
  logic [1:0]  d_size;
  logic [3:0]  d_wstrb;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_addr_ok;
  logic        d_data_ok;
  logic [31:0] d_rdata;

  logic        m_req;
  logic        m_wr;
  logic [1:0]  m_size;
  logic [3:0]  m_wstrb;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_addr_ok;
  logic        m_data_ok;
  logic [31:0] m_rdata;

  modport master (
    input  i_req, i_wr, i_size, i_wstrb, i_addr, i_wdata,
    output i_addr_ok, i_data_ok, i_rdata,
    input  d_req, d_wr, d_size, d_wstrb, d_addr, d_wdata,
    output d_addr_ok, d_data_ok, d_rdata,
    output m_req, m_wr, m_size, m_wstrb, m_addr, m_wdata,
    input  m_addr_ok, m_data_ok, m_rdata
  );

  modport slave (
    output i_req, i_wr, i_size, i_wstrb, i_addr, i_wdata,
    input  i_addr_ok, i_data_ok, i_rdata,
    output d_req, d_wr, d_size, d_wstrb, d_addr, d_wdata,
    input  d_addr_ok, d_data_ok, d_rdata,
    input  m_req, m_wr, m_size, m_wstrb, m_addr, m_wdata,
    output m_addr_ok, m_data_ok, m_rdata
  );
endinterface

// File: rtl/sram_like_arbiter.sv
// Two-into-one SRAM-like arbiter: D has fixed priority, a stalled request is locked
// until accepted or withdrawn, and an in-order ID FIFO routes responses back.
//
// state    | meaning
// S_IDLE   | no pending unaccepted request; D wins over I
// S_LOCK_I | I presented but not accepted; D ignored until I accepted or withdrawn
// S_LOCK_D | D presented but not accepted; I ignored until D accepted or withdrawn
module sram_like_arbiter #(
  parameter int MAX_OUT = 4
) (
  input  logic                clk,
  input  logic                resetn,
  sram_like_arbiter_if.master bus,
  output logic                proto_err
);

  localparam int PTR_W = $clog2(MAX_OUT);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_LOCK_I, S_LOCK_D} state_t;

  state_t             r_state;
  logic [MAX_OUT-1:0] r_fifo;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               r_proto_err;

  logic w_sel_vld;
  logic w_sel_d;
  logic w_pick_i;
  logic w_full;
  logic w_mreq;
  logic w_push;
  logic w_pop;
  logic w_head_d;

  always_comb begin
    w_sel_vld = 1'b0;
    w_sel_d   = 1'b1;
    case (r_state)
      S_LOCK_I: begin
        w_sel_vld = bus.i_req;
        w_sel_d   = 1'b0;
      end
      S_LOCK_D: begin
        w_sel_vld = bus.d_req;
        w_sel_d   = 1'b1;
      end
      default: begin
        w_sel_vld = bus.i_req | bus.d_req;
        w_sel_d   = bus.d_req | ~bus.i_req;
      end
    endcase
  end

  // A pop in this cycle does not free a slot until the next cycle.
  assign w_full   = (r_count == CNT_W'(MAX_OUT));
  assign w_mreq   = w_sel_vld & ~w_full;
  assign w_push   = w_mreq & bus.m_addr_ok;
  assign w_pop    = bus.m_data_ok & (r_count != '0);
  assign w_head_d = r_fifo[r_rd_ptr];
  assign w_pick_i = w_sel_vld & ~w_sel_d;

  assign bus.m_req   = resetn & w_mreq;
  assign bus.m_wr    = w_pick_i ? bus.i_wr    : bus.d_wr;
  assign bus.m_size  = w_pick_i ? bus.i_size  : bus.d_size;
  assign bus.m_wstrb = w_pick_i ? bus.i_wstrb : bus.d_wstrb;
  assign bus.m_addr  = w_pick_i ? bus.i_addr  : bus.d_addr;
  assign bus.m_wdata = w_pick_i ? bus.i_wdata : bus.d_wdata;

  assign bus.i_addr_ok = resetn & w_push & ~w_sel_d;
  assign bus.d_addr_ok = resetn & w_push &  w_sel_d;
  assign bus.i_data_ok = resetn & w_pop  & ~w_head_d;
  assign bus.d_data_ok = resetn & w_pop  &  w_head_d;
  assign bus.i_rdata   = bus.m_rdata;
  assign bus.d_rdata   = bus.m_rdata;

  assign proto_err = r_proto_err;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_fifo      <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_proto_err <= 1'b0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= w_sel_d;
        r_wr_ptr         <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + {{(CNT_W-1){1'b0}}, w_push} - {{(CNT_W-1){1'b0}}, w_pop};
      if (bus.m_data_ok && (r_count == '0)) r_proto_err <= 1'b1;

      case (r_state)
        S_IDLE:   if (w_mreq && !bus.m_addr_ok) r_state <= w_sel_d ? S_LOCK_D : S_LOCK_I;
        S_LOCK_I: if (!bus.i_req || w_push) r_state <= S_IDLE;
        S_LOCK_D: if (!bus.d_req || w_push) r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Bench for sram_like_arbiter: directed scenarios plus a randomized run against a
// queue-based reference model of ordering, priority and lock behaviour.
module tb_sram_like_arbiter;
  localparam int MAX_OUT = 4;

  logic clk = 1'b0;
  logic resetn;
  logic proto_err;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  sram_like_arbiter_if bus();

  sram_like_arbiter #(.MAX_OUT(MAX_OUT)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .bus      (bus),
    .proto_err(proto_err)
  );

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    bus.m_addr_ok = 1'b0; bus.m_data_ok = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    bus.i_req = 1'b1; bus.d_req = 1'b1; bus.m_addr_ok = 1'b1; bus.m_data_ok = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.m_req !== 1'b0) begin n_err++; $display("FAIL reset_m_req got=%0b exp=0", bus.m_req); end
    n_cmp++; if (bus.i_addr_ok !== 1'b0 || bus.d_addr_ok !== 1'b0) begin n_err++; $display("FAIL reset_addr_ok got=%0b%0b exp=00", bus.i_addr_ok, bus.d_addr_ok); end
    n_cmp++; if (bus.i_data_ok !== 1'b0 || bus.d_data_ok !== 1'b0) begin n_err++; $display("FAIL reset_data_ok got=%0b%0b exp=00", bus.i_data_ok, bus.d_data_ok); end
    n_cmp++; if (proto_err !== 1'b0) begin n_err++; $display("FAIL reset_proto_err got=%0b exp=0", proto_err); end
    next();
    drive_idle();
    next();
    resetn = 1'b1;
    next();
  endtask

  task automatic test_single_read();
    bus.i_req = 1'b1; bus.i_wr = 1'b0; bus.i_addr = 32'hBFC0_0000; bus.m_addr_ok = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.i_addr_ok !== 1'b1) begin n_err++; $display("FAIL single_i_addr_ok got=%0b exp=1", bus.i_addr_ok); end
    n_cmp++; if (bus.m_addr !== 32'hBFC0_0000) begin n_err++; $display("FAIL single_m_addr got=%h exp=bfc00000", bus.m_addr); end
    next();
    drive_idle();
    bus.m_data_ok = 1'b1; bus.m_rdata = 32'h2408_0001;
    @(negedge clk);
    n_cmp++; if (bus.i_data_ok !== 1'b1 || bus.d_data_ok !== 1'b0) begin n_err++; $display("FAIL single_data_ok got=%0b%0b exp=10", bus.i_data_ok, bus.d_data_ok); end
    n_cmp++; if (bus.i_rdata !== 32'h2408_0001) begin n_err++; $display("FAIL single_i_rdata got=%h exp=24080001", bus.i_rdata); end
    next();
    drive_idle();
    @(negedge clk);
    n_cmp++; if (dut.r_count !== 3'd0) begin n_err++; $display("FAIL single_count got=%0d exp=0", dut.r_count); end
    next();
  endtask

  task automatic test_priority();
    bus.i_req = 1'b1; bus.i_addr = 32'hBFC0_0004;
    bus.d_req = 1'b1; bus.d_addr = 32'h1000_0000; bus.m_addr_ok = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.d_addr_ok !== 1'b1 || bus.i_addr_ok !== 1'b0) begin n_err++; $display("FAIL prio_addr_ok got=i%0b d%0b exp=i0 d1", bus.i_addr_ok, bus.d_addr_ok); end
    n_cmp++; if (bus.m_addr !== 32'h1000_0000) begin n_err++; $display("FAIL prio_m_addr got=%h exp=10000000", bus.m_addr); end
    next();
    bus.d_req = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.i_addr_ok !== 1'b1 || bus.m_addr !== 32'hBFC0_0004) begin n_err++; $display("FAIL prio_i_next got=%0b %h exp=1 bfc00004", bus.i_addr_ok, bus.m_addr); end
    next();
    drive_idle();
    bus.m_data_ok = 1'b1; bus.m_rdata = 32'hAAAA_0001;
    @(negedge clk);
    n_cmp++; if (bus.d_data_ok !== 1'b1 || bus.i_data_ok !== 1'b0 || bus.d_rdata !== 32'hAAAA_0001) begin n_err++; $display("FAIL prio_resp0 got=i%0b d%0b %h exp=i0 d1 aaaa0001", bus.i_data_ok, bus.d_data_ok, bus.d_rdata); end
    next();
    bus.m_rdata = 32'hAAAA_0002;
    @(negedge clk);
    n_cmp++; if (bus.i_data_ok !== 1'b1 || bus.d_data_ok !== 1'b0 || bus.i_rdata !== 32'hAAAA_0002) begin n_err++; $display("FAIL prio_resp1 got=i%0b d%0b %h exp=i1 d0 aaaa0002", bus.i_data_ok, bus.d_data_ok, bus.i_rdata); end
    next();
    drive_idle();
  endtask

  task automatic test_lock();
    bus.i_req = 1'b1; bus.i_addr = 32'hBFC0_0010;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) begin bus.d_req = 1'b1; bus.d_addr = 32'h0000_2000; end
      @(negedge clk);
      n_cmp++; if (bus.m_addr !== 32'hBFC0_0010 || bus.m_req !== 1'b1) begin n_err++; $display("FAIL lock_hold_%0d got=%h req=%0b exp=bfc00010 req=1", c, bus.m_addr, bus.m_req); end
      next();
    end
    bus.m_addr_ok = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.i_addr_ok !== 1'b1 || bus.d_addr_ok !== 1'b0) begin n_err++; $display("FAIL lock_accept_i got=i%0b d%0b exp=i1 d0", bus.i_addr_ok, bus.d_addr_ok); end
    next();
    bus.i_req = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.d_addr_ok !== 1'b1 || bus.m_addr !== 32'h0000_2000) begin n_err++; $display("FAIL lock_accept_d got=%0b %h exp=1 00002000", bus.d_addr_ok, bus.m_addr); end
    next();
    drive_idle();
    bus.m_data_ok = 1'b1; bus.m_rdata = 32'h11;
    @(negedge clk);
    n_cmp++; if (bus.i_data_ok !== 1'b1 || bus.d_data_ok !== 1'b0) begin n_err++; $display("FAIL lock_resp_i got=i%0b d%0b exp=i1 d0", bus.i_data_ok, bus.d_data_ok); end
    next();
    bus.m_rdata = 32'h22;
    @(negedge clk);
    n_cmp++; if (bus.d_data_ok !== 1'b1 || bus.i_data_ok !== 1'b0) begin n_err++; $display("FAIL lock_resp_d got=i%0b d%0b exp=i0 d1", bus.i_data_ok, bus.d_data_ok); end
    next();
    drive_idle();
  endtask

  task automatic test_interleave();
    for (int k = 0; k < 4; k++) begin
      bus.i_req = (k % 2 == 0); bus.d_req = (k % 2 == 1); bus.m_addr_ok = 1'b1;
      @(negedge clk);
      n_cmp++; if (bus.i_addr_ok !== (k % 2 == 0) || bus.d_addr_ok !== (k % 2 == 1)) begin n_err++; $display("FAIL ilv_accept_%0d got=i%0b d%0b", k, bus.i_addr_ok, bus.d_addr_ok); end
      next();
    end
    drive_idle();
    for (int k = 0; k < 4; k++) begin
      bus.m_data_ok = 1'b1; bus.m_rdata = 32'(k + 1);
      @(negedge clk);
      n_cmp++; if (bus.i_data_ok !== (k % 2 == 0) || bus.d_data_ok !== (k % 2 == 1)) begin n_err++; $display("FAIL ilv_route_%0d got=i%0b d%0b", k, bus.i_data_ok, bus.d_data_ok); end
      n_cmp++; if (((k % 2 == 0) ? bus.i_rdata : bus.d_rdata) !== 32'(k + 1)) begin n_err++; $display("FAIL ilv_rdata_%0d got=%h exp=%0d", k, (k % 2 == 0) ? bus.i_rdata : bus.d_rdata, k + 1); end
      next();
    end
    drive_idle();
  endtask

  task automatic test_full();
    bus.i_req = 1'b1; bus.m_addr_ok = 1'b1;
    for (int k = 0; k < MAX_OUT; k++) begin
      @(negedge clk);
      n_cmp++; if (bus.i_addr_ok !== 1'b1) begin n_err++; $display("FAIL full_fill_%0d got=%0b exp=1", k, bus.i_addr_ok); end
      next();
    end
    @(negedge clk);
    n_cmp++; if (bus.m_req !== 1'b0 || bus.i_addr_ok !== 1'b0) begin n_err++; $display("FAIL full_block got=req%0b ok%0b exp=req0 ok0", bus.m_req, bus.i_addr_ok); end
    next();
    bus.m_data_ok = 1'b1; bus.m_rdata = 32'h55;
    @(negedge clk);
    n_cmp++; if (bus.i_data_ok !== 1'b1 || bus.m_req !== 1'b0) begin n_err++; $display("FAIL full_pop_same got=dok%0b req%0b exp=dok1 req0", bus.i_data_ok, bus.m_req); end
    next();
    bus.m_data_ok = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.m_req !== 1'b1 || bus.i_addr_ok !== 1'b1) begin n_err++; $display("FAIL full_unblock got=req%0b ok%0b exp=req1 ok1", bus.m_req, bus.i_addr_ok); end
    next();
    drive_idle();
    for (int k = 0; k < MAX_OUT; k++) begin
      bus.m_data_ok = 1'b1;
      @(negedge clk);
      n_cmp++; if (bus.i_data_ok !== 1'b1) begin n_err++; $display("FAIL full_drain_%0d got=%0b exp=1", k, bus.i_data_ok); end
      next();
    end
    drive_idle();
  endtask

  task automatic test_random();
    int q[$];
    int lock;
    int sel;
    int exp_id;
    bit mreq;
    logic [31:0] exp_addr, exp_wdata;
    logic exp_wr;
    lock = 0;
    for (int c = 0; c < 400; c++) begin
      bus.i_req = ($urandom_range(0, 3) != 0); bus.d_req = ($urandom_range(0, 2) == 0);
      bus.i_addr = $urandom; bus.d_addr = $urandom; bus.i_wdata = $urandom; bus.d_wdata = $urandom;
      bus.i_wr = 1'($urandom_range(0, 1)); bus.d_wr = 1'($urandom_range(0, 1));
      bus.i_size = 2'($urandom_range(0, 2)); bus.d_size = 2'($urandom_range(0, 2));
      bus.i_wstrb = 4'($urandom_range(0, 15)); bus.d_wstrb = 4'($urandom_range(0, 15));
      bus.m_addr_ok = 1'($urandom_range(0, 1));
      bus.m_data_ok = (q.size() > 0) && ($urandom_range(0, 2) == 0);
      bus.m_rdata = $urandom;
      if (lock == 1) sel = bus.i_req ? 1 : 0;
      else if (lock == 2) sel = bus.d_req ? 2 : 0;
      else sel = bus.d_req ? 2 : (bus.i_req ? 1 : 0);
      mreq = (sel != 0) && (q.size() < MAX_OUT);
      exp_id = bus.m_data_ok ? q[0] : 0;
      exp_addr = (sel == 1) ? bus.i_addr : bus.d_addr;
      exp_wdata = (sel == 1) ? bus.i_wdata : bus.d_wdata;
      exp_wr = (sel == 1) ? bus.i_wr : bus.d_wr;
      @(negedge clk);
      n_cmp++; if (bus.m_req !== mreq) begin n_err++; $display("FAIL rnd_m_req c=%0d got=%0b exp=%0b", c, bus.m_req, mreq); end
      n_cmp++; if (bus.i_addr_ok !== (mreq && bus.m_addr_ok && sel == 1) || bus.d_addr_ok !== (mreq && bus.m_addr_ok && sel == 2)) begin n_err++; $display("FAIL rnd_addr_ok c=%0d got=i%0b d%0b sel=%0d", c, bus.i_addr_ok, bus.d_addr_ok, sel); end
      n_cmp++; if (bus.i_data_ok !== (exp_id == 1) || bus.d_data_ok !== (exp_id == 2)) begin n_err++; $display("FAIL rnd_data_ok c=%0d got=i%0b d%0b exp_id=%0d", c, bus.i_data_ok, bus.d_data_ok, exp_id); end
      if (exp_id != 0) begin
        n_cmp++; if (((exp_id == 1) ? bus.i_rdata : bus.d_rdata) !== bus.m_rdata) begin n_err++; $display("FAIL rnd_rdata c=%0d got=%h exp=%h", c, (exp_id == 1) ? bus.i_rdata : bus.d_rdata, bus.m_rdata); end
      end
      if (mreq) begin
        n_cmp++; if (bus.m_addr !== exp_addr || bus.m_wdata !== exp_wdata || bus.m_wr !== exp_wr) begin n_err++; $display("FAIL rnd_fields c=%0d got=%h/%h/%0b exp=%h/%h/%0b", c, bus.m_addr, bus.m_wdata, bus.m_wr, exp_addr, exp_wdata, exp_wr); end
        n_cmp++; if (bus.m_size !== ((sel == 1) ? bus.i_size : bus.d_size) || bus.m_wstrb !== ((sel == 1) ? bus.i_wstrb : bus.d_wstrb)) begin n_err++; $display("FAIL rnd_size_strb c=%0d got=%0d/%h sel=%0d", c, bus.m_size, bus.m_wstrb, sel); end
      end
      if (bus.m_data_ok) void'(q.pop_front());
      if (mreq && bus.m_addr_ok) q.push_back(sel);
      if (lock == 0) begin
        if (mreq && !bus.m_addr_ok) lock = sel;
      end else if (sel == 0 || (mreq && bus.m_addr_ok)) begin
        lock = 0;
      end
      next();
    end
    drive_idle();
    while (q.size() > 0) begin
      exp_id = q.pop_front();
      bus.m_data_ok = 1'b1; bus.m_rdata = $urandom;
      @(negedge clk);
      n_cmp++; if (bus.i_data_ok !== (exp_id == 1) || bus.d_data_ok !== (exp_id == 2)) begin n_err++; $display("FAIL rnd_drain got=i%0b d%0b exp_id=%0d", bus.i_data_ok, bus.d_data_ok, exp_id); end
      next();
    end
    drive_idle();
  endtask

  task automatic test_error_reset();
    bus.m_data_ok = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.i_data_ok !== 1'b0 || bus.d_data_ok !== 1'b0) begin n_err++; $display("FAIL err_no_data_ok got=i%0b d%0b exp=i0 d0", bus.i_data_ok, bus.d_data_ok); end
    n_cmp++; if (proto_err !== 1'b0) begin n_err++; $display("FAIL err_before got=%0b exp=0", proto_err); end
    next();
    drive_idle();
    @(negedge clk);
    n_cmp++; if (proto_err !== 1'b1) begin n_err++; $display("FAIL err_sticky got=%0b exp=1", proto_err); end
    next();
    bus.i_req = 1'b1; bus.m_addr_ok = 1'b1;
    next();
    next();
    bus.m_addr_ok = 1'b0;
    next();
    bus.d_req = 1'b1;
    #2;
    resetn = 1'b0;
    bus.m_addr_ok = 1'b1;
    #1;
    n_cmp++; if (bus.m_req !== 1'b0 || bus.i_addr_ok !== 1'b0 || bus.d_addr_ok !== 1'b0) begin n_err++; $display("FAIL err_rst_force got=req%0b i%0b d%0b exp=000", bus.m_req, bus.i_addr_ok, bus.d_addr_ok); end
    drive_idle();
    next();
    resetn = 1'b1;
    @(negedge clk);
    n_cmp++; if (proto_err !== 1'b0) begin n_err++; $display("FAIL err_rst_proto got=%0b exp=0", proto_err); end
    n_cmp++; if (dut.r_count !== 3'd0) begin n_err++; $display("FAIL err_rst_count got=%0d exp=0", dut.r_count); end
    next();
    bus.i_req = 1'b1; bus.d_req = 1'b1; bus.m_addr_ok = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.d_addr_ok !== 1'b1 || bus.i_addr_ok !== 1'b0) begin n_err++; $display("FAIL err_rst_idle got=i%0b d%0b exp=i0 d1", bus.i_addr_ok, bus.d_addr_ok); end
    next();
    drive_idle();
    bus.m_data_ok = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.d_data_ok !== 1'b1) begin n_err++; $display("FAIL err_rst_resp got=%0b exp=1", bus.d_data_ok); end
    next();
    drive_idle();
  endtask

  initial begin
    resetn = 1'b0;
    drive_idle();
    bus.i_wr = 1'b0; bus.i_size = 2'd2; bus.i_wstrb = 4'hF; bus.i_addr = '0; bus.i_wdata = '0;
    bus.d_wr = 1'b0; bus.d_size = 2'd2; bus.d_wstrb = 4'hF; bus.d_addr = '0; bus.d_wdata = '0;
    bus.m_rdata = '0;
    #1;
    test_reset();
    test_single_read();
    test_priority();
    test_lock();
    test_interleave();
    test_full();
    test_random();
    test_error_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sram_like_arbiter.md
Name: sram_like_arbiter

Overview:
- Shares one SRAM-like master port between the CPU instruction-fetch port (port I) and load/store port (port D).
- Sits between the core's inst_sram_*/data_sram_* interfaces and a single downstream memory or bus bridge.
- Tracks outstanding accepted requests in an in-order source-ID FIFO, so each data_ok/rdata returns to the port that issued it.
- Fixed priority to D; a presented-but-unaccepted request is locked until its address handshake completes.

Parameters:
- MAX_OUT, 4, maximum accepted-but-not-completed requests (ID FIFO depth, power of 2, ≥2)

Ports:
- clk  in  1  clock, all state on rising edge
- resetn  in  1  asynchronous active-low reset
- i_req  in  1  port I request
- i_wr  in  1  port I write
- i_size  in  2  port I size (0=byte, 1=half, 2=word)
- i_wstrb  in  4  port I byte strobes
- i_addr  in  32  port I address
- i_wdata  in  32  port I write data
- i_addr_ok  out  1  port I address accepted
- i_data_ok  out  1  port I response valid
- i_rdata  out  32  port I read data
- d_req, d_wr, d_size, d_wstrb, d_addr, d_wdata  in  1/1/2/4/32/32  port D request fields, same meaning as port I
- d_addr_ok  out  1  port D address accepted
- d_data_ok  out  1  port D response valid
- d_rdata  out  32  port D read data
- m_req  out  1  master request
- m_wr, m_size, m_wstrb, m_addr, m_wdata  out  1/2/4/32/32  master request fields, muxed from the selected port
- m_addr_ok  in  1  master address accepted
- m_data_ok  in  1  master response valid
- m_rdata  in  32  master read data
- proto_err  out  1  sticky: m_data_ok seen with no outstanding request

Behaviour:
- Handshakes:
  - Address handshake = req & addr_ok in the same cycle.
  - Response handshake = data_ok for one cycle. Responses are in order.
- State: lock FSM {IDLE, LOCK_I, LOCK_D}; ID FIFO (MAX_OUT entries × 1 bit, 0=I, 1=D); wr/rd pointers; count (clog2(MAX_OUT)+1 bits); proto_err.
- Reset (resetn low, asynchronous):
  - FSM=IDLE, pointers=0, count=0, proto_err=0.
  - While resetn is low, m_req, i_addr_ok, d_addr_ok, i_data_ok and d_data_ok are forced 0.
- Selection in IDLE (combinational):
  - sel=D if d_req, else I if i_req.
  - m_req = (i_req | d_req) & (count != MAX_OUT).
- Selection in LOCK_x: sel=x; m_req = x_req & not full.
- Master fields: mux of the selected port's fields. When no port is selected, the fields are port D's fields (don't care).
- Address acceptance:
  - i_addr_ok = m_addr_ok & m_req & sel==I; d_addr_ok likewise for D.
  - m_addr_ok with m_req low is ignored.
- FSM transitions:
  - IDLE → LOCK_sel when m_req & !m_addr_ok.
  - LOCK_x → IDLE on m_addr_ok & m_req.
  - LOCK_x → IDLE if x_req drops (requester withdrew; legal only before acceptance).
  - Otherwise the state holds. An accepted request in IDLE stays in IDLE.
  - While locked, the other port's req is ignored even if it is D.
- FIFO push: on every master address handshake, write sel's ID, wr_ptr+1 (wraps modulo MAX_OUT).
- FIFO pop / response routing:
  - On m_data_ok with count>0: head ID routes the response.
  - ID=0 → i_data_ok=1, i_rdata=m_rdata. ID=1 → d_data_ok and d_rdata likewise.
  - rd_ptr+1 (wraps).
  - Zero added latency (combinational from m_data_ok).
- Non-selected rdata outputs: hold m_rdata (don't care); their data_ok=0.
- Full:
  - count==MAX_OUT blocks m_req.
  - A pop in the same cycle does NOT unblock that cycle's push; the push is allowed the next cycle.
- Simultaneous push and pop when not full: count unchanged, both pointers advance.
- Empty + m_data_ok:
  - No pop, no x_data_ok asserted.
  - proto_err set; it is cleared only by reset.
- The response for a request may arrive in the cycle after its address handshake, never in the same cycle. A same-cycle m_data_ok with count==0 is a protocol error.

Test Plan:
- Single I read: i_req=1 addr=0xBFC00000, m_addr_ok=1 same cycle → i_addr_ok=1, m_addr=0xBFC00000; next cycle m_data_ok=1 rdata=0x24080001 → i_data_ok=1, i_rdata=0x24080001, count returns 0.
- Priority: i_req and d_req both high in IDLE, m_addr_ok=1 → d_addr_ok=1, i_addr_ok=0, FIFO head=D. I is accepted the following cycle.
- Lock: I presented, m_addr_ok=0 for 3 cycles, d_req rises in cycle 2 → m_addr stays I's address, state LOCK_I. On m_addr_ok, I is accepted, then D is accepted in the next cycle.
- Interleaved order: accept I, D, I, D back-to-back, then 4 m_data_ok responses with rdata 1, 2, 3, 4 → i_data_ok gets 1 and 3, d_data_ok gets 2 and 4.
- Full: MAX_OUT=4 accepted with no responses → m_req=0 despite i_req=1. One m_data_ok → m_req=1 the next cycle. Pointers wrap correctly over 10 further transactions.
- Error/reset: m_data_ok with count=0 → no data_ok, proto_err=1. Assert resetn=0 mid-lock with 2 outstanding → m_req=0 immediately; after release count=0, IDLE, proto_err=0.
